// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: arbitrary depth, programmable almost-full/empty
// thresholds, optional first-word-fall-through read port and sticky error flags.
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Storage carries no reset; only the control state below is cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A fresh error event takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = mem[rd_ptr];
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO, the next generation of the team's 8-bit fixed-depth sync FIFO. It adds generic data width and depth (power of two not required), programmable almost-full and almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It sits between same-clock producer/consumer blocks as the general-purpose rate-decoupling buffer.

## Interface
- DATA_W, 8, data width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer)
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- CNT_W, $clog2(DEPTH+1), width of count (derived, not overridden)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request (FWFT: pop/acknowledge of head word)
- dout  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  CNT_W  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Accepted write: wr_acc = wr_en & ~full. Accepted read: rd_acc = rd_en & ~empty. Full/empty are evaluated on pre-edge state.
- Write: mem[wr_ptr] <= din on wr_acc. Read pointer advances on rd_acc.
- Pointers: range 0..DEPTH-1; increment, wrap DEPTH-1 -> 0 (explicit compare, not power-of-two masking).
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Full + wr_en + rd_en: read accepted, write rejected (full on pre-edge state), count → DEPTH-1, overflow set.
- Empty + wr_en + rd_en: write accepted, read rejected, count → 1, underflow set.
- Flags full/empty/almost_full/almost_empty: combinational decodes of registered count.
- overflow set on wr_en & full; underflow set on rd_en & empty. Cleared by err_clr; if set condition and err_clr coincide, set wins.
- Standard mode (FWFT=0): dout registered; loaded with mem[rd_ptr] on rd_acc, otherwise holds.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] continuously; valid whenever empty=0; rd_acc discards head and exposes next entry. dout undefined content while empty (bench must not check).
- Memory array is not reset; all control state is.

## Timing
- Reset (async assert, sync-safe release): wr_ptr=rd_ptr=0, count=0, dout=0 (standard mode), overflow=underflow=0 → empty=1, full=0, almost_empty=1, almost_full=0.
- Reset mid-operation discards all contents; first write after release lands at entry 0.
- Write → visible: count/flags update the edge after wr_acc; in FWFT, data on dout the cycle after the write to an empty FIFO.
- Standard read latency: dout valid 1 cycle after rd_acc edge (same edge count decrements).
- Throughput: one write and one read per cycle sustained.
- Error flags update the edge after the triggering request.

## Test plan
- Reset, then write 0x01..0x10 with DEPTH=16 -> full=1 after 16th edge, count=16, almost_full high from count 14; 17th write rejected, overflow=1, contents unchanged.
- Drain 16 reads (standard mode) -> dout sequence 0x01..0x10, each 1 cycle after rd_en; empty=1 after last; extra rd_en sets underflow, dout holds 0x10.
- DEPTH=5, 3 rounds of 5 writes/5 reads -> pointers wrap at 4→0, data order preserved, count returns to 0 each round.
- Simultaneous wr_en+rd_en at count=3, at full, and at empty -> count 3→3; DEPTH→DEPTH-1 with overflow=1; 0→1 with underflow=1.
- FWFT=1: write 0xA5 to empty -> dout=0xA5, empty=0 next cycle with no rd_en; rd_en pops, next word appears same cycle count decrements.
- err_clr asserted with a concurrent overflow event -> overflow stays 1; err_clr alone next cycle -> 0. Async rst pulse at count=7 -> count=0, empty=1 immediately.
